// File: rtl/ide_target_if.sv
// Bus bundle for ide_target: IDE host strobes/data plus the sector backend port.
// master = host/backend side, slave = the target.
interface ide_target_if;
    logic        ide_cs1fx;
    logic        ide_cs3fx;
    logic        ide_io_read_n;
    logic        ide_io_write_n;
    logic [2:0]  ide_address;
    logic [15:0] ide_data_bus_in;
    logic [15:0] ide_data_bus_out;
    logic        ide_intrq;

    logic        bk_req;
    logic        bk_write;
    logic [7:0]  bk_cmd;
    logic [27:0] bk_lba;
    logic [7:0]  bk_addr;
    logic        bk_wr;
    logic [15:0] bk_wdata;
    logic [15:0] bk_rdata;
    logic        bk_done;
    logic        bk_error;

    modport master (
        output ide_cs1fx, ide_cs3fx, ide_io_read_n, ide_io_write_n, ide_address, ide_data_bus_in,
        output bk_addr, bk_wr, bk_wdata, bk_done, bk_error,
        input  ide_data_bus_out, ide_intrq, bk_req, bk_write, bk_cmd, bk_lba, bk_rdata
    );

    modport slave (
        input  ide_cs1fx, ide_cs3fx, ide_io_read_n, ide_io_write_n, ide_address, ide_data_bus_in,
        input  bk_addr, bk_wr, bk_wdata, bk_done, bk_error,
        output ide_data_bus_out, ide_intrq, bk_req, bk_write, bk_cmd, bk_lba, bk_rdata
    );
endinterface

// File: rtl/ide_target.sv
// IDE (ATA PIO, LBA28) target with a one-sector buffer and a sector-request backend port.
// Define IDE_TARGET_IDENTIFY_EN to accept IDENTIFY (8'hEC) as a one-sector read.
module ide_target (
    input  logic         clock,
    input  logic         reset,
    ide_target_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DRQ_RD, DRQ_WR} state_t;

    localparam logic [7:0] CMD_READ  = 8'h20;
    localparam logic [7:0] CMD_WRITE = 8'h30;
    localparam logic [7:0] ERR_ABRT  = 8'h04;
    localparam logic [7:0] ERR_IDNF  = 8'h10;
`ifdef IDE_TARGET_IDENTIFY_EN
    localparam logic [7:0] CMD_IDENT = 8'hEC;
`endif

    state_t      state, next_state;
    logic        write_n_q, read_n_q;
    logic        rd_cs1_q;
    logic [2:0]  rd_addr_q;
    logic [7:0]  error_reg, count_reg, bk_cmd_q;
    logic [27:0] lba_reg;
    logic [3:0]  dev_hi;
    logic        err_flag, irq, nien, srst, bk_write_q, ident_q;
    logic [7:0]  ptr;
    logic [15:0] buffer [256];

    logic        cs1, cs3, wr_ev, rd_ev, reg_wr, cmd_wr, data_wr, data_rd, status_rd, devctl_wr;
    logic        last_word, more, ident_ok;
    logic [7:0]  cmd_code, count_dec, status;
    logic        accept_cmd, abort, idnf, advance, sector_irq, to_store;

    assign cs1       = !bus.ide_cs1fx;
    assign cs3       = !bus.ide_cs3fx;
    assign wr_ev     = !bus.ide_io_write_n && write_n_q;
    assign rd_ev     = bus.ide_io_read_n && !read_n_q;
    assign reg_wr    = wr_ev && cs1 && !srst && (state == IDLE);
    assign cmd_wr    = reg_wr && (bus.ide_address == 3'd7);
    assign data_wr   = wr_ev && cs1 && !srst && (bus.ide_address == 3'd0) && (state == DRQ_WR);
    assign data_rd   = rd_ev && rd_cs1_q && (rd_addr_q == 3'd0) && (state == DRQ_RD);
    assign status_rd = rd_ev && rd_cs1_q && (rd_addr_q == 3'd7);
    assign devctl_wr = wr_ev && cs3 && (bus.ide_address == 3'd6);
    assign cmd_code  = bus.ide_data_bus_in[7:0];
    assign last_word = (ptr == 8'hFF);
    assign count_dec = count_reg - 8'd1;
    assign more      = (count_dec != 8'd0);
`ifdef IDE_TARGET_IDENTIFY_EN
    assign ident_ok  = (cmd_code == CMD_IDENT);
`else
    assign ident_ok  = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
    always_comb begin
        next_state = state;
        accept_cmd = 1'b0;
        abort      = 1'b0;
        idnf       = 1'b0;
        advance    = 1'b0;
        sector_irq = 1'b0;
        to_store   = 1'b0;
        case (state)
            IDLE: if (cmd_wr) begin
                if (cmd_code == CMD_READ || ident_ok) begin
                    next_state = BUSY;
                    accept_cmd = 1'b1;
                end else if (cmd_code == CMD_WRITE) begin
                    next_state = DRQ_WR;
                    accept_cmd = 1'b1;
                end else begin
                    abort = 1'b1;
                end
            end
            BUSY: if (bus.bk_done) begin
                if (bus.bk_error) begin
                    next_state = IDLE;
                    idnf       = 1'b1;
                end else if (!bk_write_q) begin
                    next_state = DRQ_RD;
                    sector_irq = 1'b1;
                end else begin
                    advance    = 1'b1;
                    sector_irq = 1'b1;
                    next_state = more ? DRQ_WR : IDLE;
                end
            end
            DRQ_RD: if (data_rd && last_word) begin
                if (ident_q) begin
                    next_state = IDLE;
                end else begin
                    advance    = 1'b1;
                    next_state = more ? BUSY : IDLE;
                end
            end
            DRQ_WR: if (data_wr && last_word) begin
                next_state = BUSY;
                to_store   = 1'b1;
            end
            default: next_state = IDLE;
        endcase
        // Soft reset pins the machine in IDLE and suppresses every side effect.
        if (srst) begin
            next_state = IDLE;
            accept_cmd = 1'b0;
            abort      = 1'b0;
            idnf       = 1'b0;
            advance    = 1'b0;
            sector_irq = 1'b0;
            to_store   = 1'b0;
        end
    end

    // Strobe history; the read target is latched while the strobe is low so the
    // side effect on its trailing edge does not depend on the host holding the address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_n_q <= 1'b1;
            read_n_q  <= 1'b1;
            rd_cs1_q  <= 1'b0;
            rd_addr_q <= 3'd0;
        end else begin
            write_n_q <= bus.ide_io_write_n;
            read_n_q  <= bus.ide_io_read_n;
            if (!bus.ide_io_read_n) begin
                rd_cs1_q  <= cs1;
                rd_addr_q <= bus.ide_address;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nien <= 1'b0;
            srst <= 1'b0;
        end else if (devctl_wr) begin
            nien <= bus.ide_data_bus_in[1];
            srst <= bus.ide_data_bus_in[2];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            error_reg  <= 8'h01;
            count_reg  <= 8'h01;
            lba_reg    <= 28'd0;
            dev_hi     <= 4'd0;
            err_flag   <= 1'b0;
            irq        <= 1'b0;
            ptr        <= 8'd0;
            bk_write_q <= 1'b0;
            bk_cmd_q   <= 8'h00;
            ident_q    <= 1'b0;
        end else if (srst) begin
            error_reg  <= 8'h01;
            count_reg  <= 8'h01;
            lba_reg    <= 28'd0;
            err_flag   <= 1'b0;
            irq        <= 1'b0;
            ptr        <= 8'd0;
            bk_write_q <= 1'b0;
            bk_cmd_q   <= 8'h00;
            ident_q    <= 1'b0;
        end else begin
            if (reg_wr) begin
                case (bus.ide_address)
                    3'd2: count_reg       <= cmd_code;
                    3'd3: lba_reg[7:0]    <= cmd_code;
                    3'd4: lba_reg[15:8]   <= cmd_code;
                    3'd5: lba_reg[23:16]  <= cmd_code;
                    3'd6: begin
                        dev_hi         <= cmd_code[7:4];
                        lba_reg[27:24] <= cmd_code[3:0];
                    end
                    default: ;
                endcase
            end
            if (cmd_wr || status_rd) irq <= 1'b0;
            if (cmd_wr) err_flag <= 1'b0;
            if (accept_cmd) begin
                bk_cmd_q   <= cmd_code;
                bk_write_q <= (cmd_code == CMD_WRITE);
                ident_q    <= ident_ok;
            end
            if (abort) begin
                error_reg <= ERR_ABRT;
                err_flag  <= 1'b1;
            end
            if (idnf) begin
                error_reg <= ERR_IDNF;
                err_flag  <= 1'b1;
            end
            if (abort || idnf || sector_irq) irq <= 1'b1;
            if (advance) begin
                count_reg <= count_dec;
                lba_reg   <= lba_reg + 28'd1;
            end
            if (to_store) bk_write_q <= 1'b1;
            if (next_state != state && (next_state == DRQ_RD || next_state == DRQ_WR))
                ptr <= 8'd0;
            else if (data_rd || data_wr)
                ptr <= ptr + 8'd1;
        end
    end

    // NOTE: the sector buffer has no reset; its contents are only meaningful after a fill or host write.
    always_ff @(posedge clock) begin
        if (data_wr)
            buffer[ptr] <= bus.ide_data_bus_in;
        else if (bus.bk_wr && state == BUSY && !bk_write_q && !srst)
            buffer[bus.bk_addr] <= bus.bk_wdata;
    end

    always_comb begin
        case (state)
            IDLE:    status = {7'b0101000, err_flag};
            BUSY:    status = 8'h80;
            default: status = 8'h58;
        endcase
    end

    always_comb begin
        bus.ide_data_bus_out = 16'hFFFF;
        if (!bus.ide_io_read_n && (cs1 || cs3)) begin
            bus.ide_data_bus_out = 16'h0000;
            if (cs1) begin
                case (bus.ide_address)
                    3'd0: bus.ide_data_bus_out = buffer[ptr];
                    3'd1: bus.ide_data_bus_out = {8'h00, error_reg};
                    3'd2: bus.ide_data_bus_out = {8'h00, count_reg};
                    3'd3: bus.ide_data_bus_out = {8'h00, lba_reg[7:0]};
                    3'd4: bus.ide_data_bus_out = {8'h00, lba_reg[15:8]};
                    3'd5: bus.ide_data_bus_out = {8'h00, lba_reg[23:16]};
                    3'd6: bus.ide_data_bus_out = {8'h00, dev_hi, lba_reg[27:24]};
                    default: bus.ide_data_bus_out = {8'h00, status};
                endcase
            end else if (bus.ide_address == 3'd6) begin
                bus.ide_data_bus_out = {8'h00, status};
            end
        end
    end

    assign bus.ide_intrq = irq & ~nien;
    assign bus.bk_req    = (state == BUSY);
    assign bus.bk_write  = bk_write_q;
    assign bus.bk_cmd    = bk_cmd_q;
    assign bus.bk_lba    = lba_reg;
    assign bus.bk_rdata  = buffer[bus.bk_addr];
endmodule

// File: tb/tb_ide_target.sv
// Scoreboard bench for ide_target: backend fill data and host write data are queued
// as they are driven and popped when the other side reads them back.
module tb_ide_target;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ide_target_if bus();
    ide_target dut (.clock(clock), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fails  = 0;
    logic [15:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic host_write(input logic is_cs3, input logic [2:0] addr, input logic [15:0] data);
        @(negedge clock);
        bus.ide_cs1fx       = is_cs3;
        bus.ide_cs3fx       = !is_cs3;
        bus.ide_address     = addr;
        bus.ide_data_bus_in = data;
        bus.ide_io_write_n  = 1'b0;
        @(negedge clock);
        bus.ide_io_write_n  = 1'b1;
        bus.ide_cs1fx       = 1'b1;
        bus.ide_cs3fx       = 1'b1;
    endtask

    task automatic host_read(input logic is_cs3, input logic [2:0] addr, output logic [15:0] data);
        @(negedge clock);
        bus.ide_cs1fx      = is_cs3;
        bus.ide_cs3fx      = !is_cs3;
        bus.ide_address    = addr;
        bus.ide_io_read_n  = 1'b0;
        #1 data = bus.ide_data_bus_out;
        @(negedge clock);
        bus.ide_io_read_n  = 1'b1;
        bus.ide_cs1fx      = 1'b1;
        bus.ide_cs3fx      = 1'b1;
        @(negedge clock);
    endtask

    task automatic reg_check(input string tag, input logic is_cs3, input logic [2:0] addr,
                             input logic [15:0] exp);
        logic [15:0] d;
        host_read(is_cs3, addr, d);
        check(tag, {16'h0, d}, {16'h0, exp});
    endtask

    task automatic setup(input logic [7:0] count, input logic [27:0] lba);
        host_write(1'b0, 3'd2, {8'h00, count});
        host_write(1'b0, 3'd3, {8'h00, lba[7:0]});
        host_write(1'b0, 3'd4, {8'h00, lba[15:8]});
        host_write(1'b0, 3'd5, {8'h00, lba[23:16]});
        host_write(1'b0, 3'd6, {8'h00, 4'hE, lba[27:24]});
    endtask

    task automatic wait_req();
        int k = 0;
        while (bus.bk_req !== 1'b1 && k < 200) begin
            @(negedge clock);
            k++;
        end
        check("bk_req_seen", {31'h0, bus.bk_req}, 32'h1);
    endtask

    task automatic bk_done_pulse(input logic err);
        @(negedge clock);
        bus.bk_wr    = 1'b0;
        bus.bk_done  = 1'b1;
        bus.bk_error = err;
        @(negedge clock);
        bus.bk_done  = 1'b0;
        bus.bk_error = 1'b0;
    endtask

    // Backend side of a read: fill the buffer with random words and queue them.
    task automatic bk_serve(input logic [27:0] exp_lba, input logic [7:0] exp_cmd, input logic err);
        wait_req();
        check("bk_lba", {4'h0, bus.bk_lba}, {4'h0, exp_lba});
        check("bk_cmd", {24'h0, bus.bk_cmd}, {24'h0, exp_cmd});
        check("bk_write_rd", {31'h0, bus.bk_write}, 32'h0);
        if (!err) begin
            for (int i = 0; i < 256; i++) begin
                @(negedge clock);
                bus.bk_addr  = i[7:0];
                bus.bk_wdata = 16'($urandom);
                bus.bk_wr    = 1'b1;
                sb_q.push_back(bus.bk_wdata);
            end
        end
        check("bk_req_hold", {31'h0, bus.bk_req}, 32'h1);
        check("bk_lba_hold", {4'h0, bus.bk_lba}, {4'h0, exp_lba});
        bk_done_pulse(err);
    endtask

    task automatic read_sector();
        logic [15:0] d;
        for (int i = 0; i < 256; i++) begin
            host_read(1'b0, 3'd0, d);
            if (sb_q.size() == 0) check("sb_underflow", 32'h1, 32'h0);
            else                  check("data_word", {16'h0, d}, {16'h0, sb_q.pop_front()});
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        reset = 1'b1;
        bus.ide_cs1fx = 1'b1;        bus.ide_cs3fx = 1'b1;
        bus.ide_io_read_n = 1'b1;    bus.ide_io_write_n = 1'b1;
        bus.ide_address = 3'd0;      bus.ide_data_bus_in = 16'h0;
        bus.bk_addr = 8'h0;          bus.bk_wr = 1'b0;   bus.bk_wdata = 16'h0;
        bus.bk_done = 1'b0;          bus.bk_error = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        check("rst_bus_idle", {16'h0, bus.ide_data_bus_out}, 32'hFFFF);
        bus.ide_io_read_n = 1'b0;
        #1 check("rd_no_cs", {16'h0, bus.ide_data_bus_out}, 32'hFFFF);
        bus.ide_io_read_n = 1'b1;
        check("rst_intrq", {31'h0, bus.ide_intrq}, 32'h0);
        check("rst_bk_req", {31'h0, bus.bk_req}, 32'h0);
        check("rst_bk_cmd", {24'h0, bus.bk_cmd}, 32'h0);
        check("rst_bk_lba", {4'h0, bus.bk_lba}, 32'h0);
        reg_check("rst_status", 1'b0, 3'd7, 16'h0050);
        reg_check("rst_error", 1'b0, 3'd1, 16'h0001);
        reg_check("rst_count", 1'b0, 3'd2, 16'h0001);
        reg_check("rst_lba0", 1'b0, 3'd3, 16'h0000);

        // Two-sector read crossing an LBA byte boundary
        setup(8'd2, 28'h0000FFF);
        host_write(1'b0, 3'd7, 16'h0020);
        reg_check("busy_status", 1'b0, 3'd7, 16'h0080);
        host_write(1'b0, 3'd2, 16'h0077);
        reg_check("busy_count_ignored", 1'b0, 3'd2, 16'h0002);
        bk_serve(28'h0000FFF, 8'h20, 1'b0);
        check("rd_irq", {31'h0, bus.ide_intrq}, 32'h1);
        reg_check("drq_status", 1'b0, 3'd7, 16'h0058);
        check("rd_irq_clr", {31'h0, bus.ide_intrq}, 32'h0);
        read_sector();
        bk_serve(28'h0001000, 8'h20, 1'b0);
        read_sector();
        reg_check("rd2_status", 1'b0, 3'd7, 16'h0050);
        reg_check("rd2_count", 1'b0, 2'd2, 16'h0000);
        reg_check("rd2_lba0", 1'b0, 3'd3, 16'h0001);
        reg_check("rd2_lba1", 1'b0, 3'd4, 16'h0010);

        // One-sector write
        setup(8'd1, 28'h0000010);
        host_write(1'b0, 3'd7, 16'h0030);
        reg_check("wr_drq_status", 1'b0, 3'd7, 16'h0058);
        for (int i = 0; i < 256; i++) begin
            host_write(1'b0, 3'd0, i[15:0]);
            sb_q.push_back(i[15:0]);
        end
        wait_req();
        check("bk_write_wr", {31'h0, bus.bk_write}, 32'h1);
        check("bk_cmd_wr", {24'h0, bus.bk_cmd}, 32'h30);
        for (int a = 0; a < 256; a++) begin
            @(negedge clock);
            bus.bk_addr = a[7:0];
            #1 check("bk_rdata", {16'h0, bus.bk_rdata}, {16'h0, sb_q.pop_front()});
        end
        @(negedge clock);
        bus.bk_addr = 8'd5;
        #1 check("bk_rdata_5", {16'h0, bus.bk_rdata}, 32'h0005);
        bk_done_pulse(1'b0);
        check("wr_irq", {31'h0, bus.ide_intrq}, 32'h1);
        reg_check("wr_status", 1'b0, 3'd7, 16'h0050);
        reg_check("wr_count", 1'b0, 3'd2, 16'h0000);
        reg_check("wr_lba0", 1'b0, 3'd3, 16'h0011);

        // Unknown command aborts; alt-status does not clear IRQ
        host_write(1'b0, 3'd7, 16'h0099);
        check("abrt_irq", {31'h0, bus.ide_intrq}, 32'h1);
        reg_check("abrt_alt", 1'b1, 3'd6, 16'h0051);
        check("abrt_irq_alt", {31'h0, bus.ide_intrq}, 32'h1);
        reg_check("abrt_error", 1'b0, 3'd1, 16'h0004);
        reg_check("abrt_status", 1'b0, 3'd7, 16'h0051);
        check("abrt_irq_clr", {31'h0, bus.ide_intrq}, 32'h0);

        // Backend failure
        setup(8'd1, 28'h0000020);
        host_write(1'b0, 3'd7, 16'h0020);
        bk_serve(28'h0000020, 8'h20, 1'b1);
        check("idnf_irq", {31'h0, bus.ide_intrq}, 32'h1);
        reg_check("idnf_error", 1'b0, 3'd1, 16'h0010);
        reg_check("idnf_status", 1'b0, 3'd7, 16'h0051);

        // Interrupt masked by nIEN
        host_write(1'b1, 3'd6, 16'h0002);
        setup(8'd1, 28'h0000030);
        host_write(1'b0, 3'd7, 16'h0020);
        bk_serve(28'h0000030, 8'h20, 1'b0);
        check("nien_intrq", {31'h0, bus.ide_intrq}, 32'h0);
        reg_check("nien_alt", 1'b1, 3'd6, 16'h0058);
        read_sector();
        reg_check("nien_status", 1'b0, 3'd7, 16'h0050);
        host_write(1'b1, 3'd6, 16'h0000);

        // Soft reset mid DRQ_RD
        setup(8'd2, 28'h0000040);
        host_write(1'b0, 3'd7, 16'h0020);
        bk_serve(28'h0000040, 8'h20, 1'b0);
        for (int i = 0; i < 10; i++) begin
            host_read(1'b0, 3'd0, d);
            check("srst_pre_word", {16'h0, d}, {16'h0, sb_q.pop_front()});
        end
        host_write(1'b1, 3'd6, 16'h0004);
        host_write(1'b1, 3'd6, 16'h0000);
        sb_q.delete();
        reg_check("srst_status", 1'b0, 3'd7, 16'h0050);
        reg_check("srst_error", 1'b0, 3'd1, 16'h0001);
        reg_check("srst_count", 1'b0, 3'd2, 16'h0001);
        check("srst_bk_req", {31'h0, bus.bk_req}, 32'h0);
        check("srst_bk_cmd", {24'h0, bus.bk_cmd}, 32'h0);
        check("srst_bk_lba", {4'h0, bus.bk_lba}, 32'h0);

        // LBA wrap at the top of the 28-bit space
        setup(8'd2, 28'hFFFFFFF);
        host_write(1'b0, 3'd7, 16'h0020);
        bk_serve(28'hFFFFFFF, 8'h20, 1'b0);
        read_sector();
        bk_serve(28'h0000000, 8'h20, 1'b0);
        read_sector();
        reg_check("wrap_status", 1'b0, 3'd7, 16'h0050);
        reg_check("wrap_count", 1'b0, 3'd2, 16'h0000);
        reg_check("wrap_dev", 1'b0, 3'd6, 16'h00E0);

        // IDENTIFY
        setup(8'd3, 28'h0000055);
        host_write(1'b0, 3'd7, 16'h00EC);
`ifdef IDE_TARGET_IDENTIFY_EN
        bk_serve(28'h0000055, 8'hEC, 1'b0);
        read_sector();
        reg_check("ident_status", 1'b0, 3'd7, 16'h0050);
        reg_check("ident_count", 1'b0, 3'd2, 16'h0003);
        reg_check("ident_lba0", 1'b0, 3'd3, 16'h0055);
        check("ident_bk_req", {31'h0, bus.bk_req}, 32'h0);
`else
        reg_check("ident_status", 1'b0, 3'd7, 16'h0051);
        reg_check("ident_error", 1'b0, 3'd1, 16'h0004);
        check("ident_bk_req", {31'h0, bus.bk_req}, 32'h0);
`endif

        check("sb_drained", sb_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/ide_target.md
IDE_TARGET -- requirements
Module: ide_target

Interface
REQ-001 SHALL have: clock  input  1  system clock; IDE strobes are synchronous to it.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high.
REQ-003 SHALL have: ide_cs1fx / ide_cs3fx  input  1 each  active-low command-block / control-block selects.
REQ-004 SHALL have: ide_io_read_n / ide_io_write_n  input  1 each  active-low host strobes; ide_address  input  3  register index.
REQ-005 SHALL have: ide_data_bus_in  input  16  host write data; ide_data_bus_out  output  16  read data; ide_intrq  output  1  interrupt request.
REQ-006 SHALL have: bk_req  output  1  sector request; bk_write  output  1  1=store to media, 0=fill buffer; bk_cmd  output  8  command code; bk_lba  output  28  current sector.
REQ-007 SHALL have: bk_addr  input  8  buffer word index; bk_wr  input  1  buffer write strobe; bk_wdata  input  16  buffer data; bk_rdata  output  16  buffer[bk_addr]; bk_done  input  1  sector complete pulse; bk_error  input  1  failure flag, sampled with bk_done.

Function
REQ-008 SHALL decode CS1 registers 0 data, 1 error(R)/features(W), 2 sector count, 3-5 LBA[7:0]/[15:8]/[23:16], 6 device (LBA[27:24] in bits 3:0), 7 status(R)/command(W); CS3 register 6 alt-status(R)/device-control(W: bit1 nIEN, bit2 SRST).
REQ-009 SHALL capture writes on the first clock with io_write_n low after high, using ide_data_bus_in[7:0] (full 16 bits for the data port).
REQ-010 SHALL drive ide_data_bus_out combinationally from the selected register while io_read_n low and a select is active, 16'hFFFF otherwise; 8-bit registers zero-extended.
REQ-011 SHALL apply read side effects (data-port pointer advance, IRQ clear on status read) on the first clock with io_read_n high after low.
REQ-012 SHALL implement states IDLE, BUSY, DRQ_RD, DRQ_WR; status = BSY(7) DRDY(6) DSC(4) DRQ(3) ERR(0): IDLE 8'h50 (|ERR), BUSY 8'h80, DRQ_* 8'h58.
REQ-013 SHALL accept command writes only in IDLE: 8'h20 -> BUSY with bk_write=0; 8'h30 -> DRQ_WR, pointer 0; other codes -> IDLE, error 8'h04 (ABRT), ERR set, IRQ set; writes to registers 1-7 outside IDLE SHALL be ignored.
REQ-014 SHALL hold bk_req high in BUSY until bk_done; bk_cmd and bk_lba stable throughout.
REQ-015 SHALL, on bk_done with bk_error=0 for a read, enter DRQ_RD, pointer 0, IRQ set; with bk_error=1, enter IDLE, error 8'h10 (IDNF), ERR, IRQ.
REQ-016 SHALL return buffer[pointer] on data-port reads; the 256th word read decrements count, increments LBA, then enters BUSY if count remains, else IDLE.
REQ-017 SHALL store data-port writes in DRQ_WR to buffer[pointer]; after word 256 enter BUSY with bk_write=1; bk_done then advances count/LBA, sets IRQ, and re-enters DRQ_WR or IDLE.
REQ-018 SHALL treat sector count 0 as 256 sectors; LBA SHALL wrap 28'hFFFFFFF -> 0; count/LBA registers SHALL read back the advanced values.
REQ-019 SHALL ignore bk_wr outside BUSY-with-bk_write=0 and bk_done outside BUSY; data-port accesses outside DRQ_* SHALL not move the pointer.
REQ-020 SHALL drive ide_intrq = irq & ~nIEN; irq cleared by CS1 status read, command write, or reset; alt-status read SHALL not clear it.

Reset
REQ-021 SHALL, on reset or SRST=1, enter IDLE: error 8'h01, count 8'h01, LBA 0, irq 0, pointer 0, bk_req 0, bk_write 0, bk_cmd 8'h00; nIEN cleared by reset only; buffer contents not cleared.
REQ-022 SHALL hold all states at reset while SRST=1; reset mid-transfer abandons the sector with no bk_done expected.

Configuration
REQ-023 SHALL, with IDE_TARGET_IDENTIFY_EN defined, accept 8'hEC as a one-sector read (bk_cmd=8'hEC, count/LBA unchanged on completion); without it 8'hEC SHALL abort per REQ-013.

Verification
REQ-024 SHALL cover: count=2, LBA=0x0000FFF, cmd 8'h20, backend fills twice -> 512 words read, bk_lba 0x0000FFF then 0x0001000, final status 8'h50, count 0.
REQ-025 SHALL cover: cmd 8'h30 count=1, 256 writes of i -> bk_write=1, bk_rdata at bk_addr 5 = 16'h0005, bk_done -> IRQ, status 8'h50.
REQ-026 SHALL cover: cmd 8'h99 -> status 8'h51, error 8'h04, ide_intrq 1; status read -> ide_intrq 0.
REQ-027 SHALL cover: nIEN=1 with completed read -> ide_intrq 0 while status shows DRQ 8'h58.
REQ-028 SHALL cover: SRST pulse mid DRQ_RD -> status 8'h50, error 8'h01, bk_req 0; LBA 28'hFFFFFFF count 2 read -> second bk_lba 0.
REQ-029 SHALL cover: cmd 8'hEC -> bk_cmd 8'hEC, single sector, if IDE_TARGET_IDENTIFY_EN; else status 8'h51.
